// File: rtl/dmem_stage.sv
// dmem_stage: MEM pipeline stage with a single-cycle word-addressed data memory
// and the MEM/WB pipeline register.
//
// Ports
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   ex_*              : EX/MEM entry (valid, control, ALU result/address, store data, rd)
//   stall             : hold MEM/WB and suppress the store
//   flush             : squash the instruction in MEM
//   wb_valid, wb_reg_write, wb_rd, wb_data : MEM/WB register (wb_data is the forwarding source)
//   mem_err, err_addr : sticky access-fault flag and address of the first fault
module dmem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        stall,
    input  logic        flush,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err,
    output logic [31:0] err_addr
);

    logic [31:0]   mem [DEPTH];

    logic          access;
    logic          fault;
    logic          normal;
    logic          store_en;
    logic          load_sel;
    logic [AW-1:0] idx;
    logic [31:0]   rd_data;
    logic [31:0]   next_data;

    assign access   = ex_valid & (ex_mem_read | ex_mem_write);
    assign idx      = ex_alu_result[AW+1:2];
    assign fault    = access & ((|ex_alu_result[1:0]) | (|ex_alu_result[31:AW+2]));
    assign normal   = ~flush & ~stall;
    assign store_en = normal & access & ex_mem_write & ~fault;
    // Read+write together is illegal: the store wins and the ALU result is written back.
    assign load_sel = ex_mem_read & ~ex_mem_write & ex_mem_to_reg;

    // Asynchronous read: a store at edge N is visible to a load at edge N+1.
    assign rd_data = mem[idx];

    always_comb begin
        next_data = ex_alu_result;
        if (load_sel)
            next_data = fault ? 32'h0 : rd_data;
    end

    // Memory contents are intentionally not reset; stores are blocked while in reset.
    always @(posedge clk) begin
        if (rst_n && store_en)
            mem[idx] <= ex_store_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            mem_err      <= 1'b0;
            err_addr     <= '0;
        end else if (flush) begin
            // wb_rd/wb_data are don't-care after a flush; holding them saves enables.
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= ex_valid;
            wb_reg_write <= ex_valid & ex_reg_write;
            wb_rd        <= ex_rd;
            wb_data      <= next_data;
            // Only the first fault is latched; later ones leave err_addr alone.
            if (fault && !mem_err) begin
                mem_err  <= 1'b1;
                err_addr <= ex_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
module tb_dmem_stage;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, flush;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, err_addr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    logic        m_valid, m_regw, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_eaddr;

    dmem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_err(mem_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_regw = 0; m_rd = 0; m_data = 0; m_err = 0; m_eaddr = 0;
    endtask

    // Behavioural view of one rising edge, using byte-address arithmetic.
    task automatic model_edge();
        bit          active, bad;
        int unsigned a, i;
        logic [31:0] d;
        if (!rst_n) return;
        a      = ex_alu_result;
        active = ex_valid && (ex_mem_read || ex_mem_write);
        bad    = active && ((a % 4) != 0 || a >= DEPTH * 4);
        i      = (a / 4) % DEPTH;
        if (flush) begin
            m_valid = 0; m_regw = 0;
        end else if (!stall) begin
            if (ex_mem_read && !ex_mem_write && ex_mem_to_reg)
                d = bad ? 32'h0 : ref_mem[i];
            else
                d = ex_alu_result;
            if (active && ex_mem_write && !bad) ref_mem[i] = ex_store_data;
            m_valid = ex_valid;
            m_regw  = ex_valid && ex_reg_write;
            m_rd    = ex_rd;
            m_data  = d;
            if (bad && !m_err) begin m_err = 1; m_eaddr = ex_alu_result; end
        end
    endtask

    task automatic check_all();
        chk("wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(m_regw));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("err_addr", err_addr, m_eaddr);
        if (m_valid) begin
            chk("wb_rd", 32'(wb_rd), 32'(m_rd));
            chk("wb_data", wb_data, m_data);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit r, input bit w, input bit rw, input bit m2r,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input bit st, input bit fl);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_reg_write = rw;
        ex_mem_to_reg = m2r; ex_alu_result = addr; ex_store_data = sd; ex_rd = rd;
        stall = st; flush = fl;
    endtask

    // Assert reset between edges (called at posedge+1), hold an active store through
    // one edge in reset, then release on the following negedge.
    task automatic reset_pulse(input int unsigned widx);
        logic [31:0] keep;
        keep = ref_mem[widx];
        #2 rst_n = 0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_wb_regw", 32'(wb_reg_write), 32'h0);
        chk("rst_wb_rd", 32'(wb_rd), 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_mem_err", 32'(mem_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        model_reset();
        drive(1, 0, 1, 0, 0, widx * 4, ~keep, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_no_store", dut.mem[widx], keep);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] v;
        int unsigned sel, op, ix;
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            dut.mem[i] <= v;
        end
        #1;
        chk("init_wb_valid", 32'(wb_valid), 32'h0);
        chk("init_wb_data", wb_data, 32'h0);
        chk("init_mem_err", 32'(mem_err), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Store then immediate load of the same word
        drive(1, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0); cycle();
        drive(1, 1, 0, 1, 1, 32'h10, 0, 3, 0, 0);            cycle();
        chk("ld_after_st", wb_data, 32'hDEADBEEF);
        chk("ld_regw", 32'(wb_reg_write), 32'h1);

        // Plain ALU result writeback
        drive(1, 0, 0, 1, 0, 32'h2A, 0, 5, 0, 0); cycle();
        chk("alu_data", wb_data, 32'h2A);
        chk("alu_rd", 32'(wb_rd), 32'h5);

        // Misaligned load faults, later out-of-range load keeps the first address
        drive(1, 1, 0, 1, 1, 32'h13, 0, 7, 0, 0);   cycle();
        chk("mis_data", wb_data, 32'h0);
        chk("mis_err", 32'(mem_err), 32'h1);
        chk("mis_addr", err_addr, 32'h13);
        drive(1, 1, 0, 1, 1, 32'h2000, 0, 8, 0, 0); cycle();
        chk("oor_addr_kept", err_addr, 32'h13);

        // Stalled store, then flushed+stalled store
        v = ref_mem[8];
        drive(1, 0, 1, 0, 0, 32'h20, 32'h1234, 9, 1, 0); cycle();
        chk("stall_mem8", dut.mem[8], v);
        chk("stall_hold_rd", 32'(wb_rd), 32'h8);
        drive(1, 0, 1, 0, 0, 32'h20, 32'h1234, 9, 1, 1); cycle();
        chk("flush_valid", 32'(wb_valid), 32'h0);
        chk("flush_mem8", dut.mem[8], v);

        // Reset between edges while wb_valid=1
        drive(1, 1, 0, 1, 1, 32'h10, 0, 4, 0, 0); cycle();
        chk("pre_rst_valid", 32'(wb_valid), 32'h1);
        reset_pulse(4);
        drive(1, 1, 0, 1, 1, 32'h10, 0, 6, 0, 0); cycle();
        chk("post_rst_load", wb_data, ref_mem[4]);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            ix  = $urandom_range(0, DEPTH - 1);
            case (sel)
                7:       v = ix * 4 + $urandom_range(1, 3);
                8:       v = (ix * 4) | (32'h1 << $urandom_range(AW + 2, 31));
                9:       v = $urandom;
                default: v = ix * 4;
            endcase
            op = $urandom_range(0, 15);
            drive($urandom_range(0, 7) != 0,
                  op inside {[1:5], 15}, op inside {[6:9], 15},
                  $urandom_range(0, 1), (op inside {[1:5], 15}) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
                  v, $urandom, 5'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            cycle();
            if ($urandom_range(0, 299) == 0) reset_pulse($urandom_range(0, DEPTH - 1));
        end

        for (int i = 0; i < DEPTH; i += 17)
            chk("final_mem", dut.mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
